// File: rtl/pool_window_feeder.sv
// pool_window_feeder
//   Streaming 2x2 window assembler for the max-pool comparator. Pixels come in
//   row-major, one per handshake. Even rows are parked in a line buffer. On odd
//   rows, each odd-column pixel completes a non-overlapping 2x2 window. That
//   window is loaded into a single-entry valid/ready output register.
//
//   Ports
//     clk, rst_n        clock, asynchronous active-low reset
//     in_valid/ready    pixel handshake; in_data is 8-bit sign-magnitude
//     win_valid/ready   window handshake
//     win_data          {bottom-right, bottom-left, top-right, top-left}
//     win_last          final window of the frame
//
//   Build option
//     POOL_FEED_NEGZERO_SQUASH_EN : when defined, an accepted 8'h80 (negative
//     zero) is replaced by 8'h00 before it is stored or packed.
module pool_window_feeder #(
    parameter int IMG_W = 28,
    parameter int IMG_H = 28
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [7:0]  in_data,
    output logic        win_valid,
    input  logic        win_ready,
    output logic [31:0] win_data,
    output logic        win_last
);

    localparam int CW = (IMG_W > 1) ? $clog2(IMG_W) : 1;
    localparam int RW = (IMG_H > 1) ? $clog2(IMG_H) : 1;
    localparam logic [CW-1:0] COL_MAX = CW'(IMG_W - 1);
    localparam logic [RW-1:0] ROW_MAX = RW'(IMG_H - 1);

    typedef enum logic {FILL_EVEN, PAIR_ODD} state_e;

    state_e          state_q, state_d;
    logic [CW-1:0]   col_q, col_d;
    logic [RW-1:0]   row_q, row_d;
    logic [7:0]      left_q, left_d;
    logic [31:0]     win_data_q, win_data_d;
    logic            win_valid_q, win_valid_d;
    logic            win_last_q, win_last_d;
    logic [7:0]      linebuf_q [IMG_W];

    logic [7:0]      px;
    logic            col_wrap, row_wrap, lb_we;
    logic [7:0]      top_l, top_r;

`ifdef POOL_FEED_NEGZERO_SQUASH_EN
    assign px = (in_data == 8'h80) ? 8'h00 : in_data;
`else
    assign px = in_data;
`endif

    assign col_wrap = (col_q == COL_MAX);
    assign row_wrap = (row_q == ROW_MAX);

    // Windows only complete at odd columns. The top-left column is therefore
    // the current column with its LSB cleared.
    assign top_r = linebuf_q[col_q];
    assign top_l = linebuf_q[col_q & ~CW'(1)];

    always_comb begin
        state_d     = state_q;
        col_d       = col_q;
        row_d       = row_q;
        left_d      = left_q;
        win_data_d  = win_data_q;
        win_valid_d = win_valid_q;
        win_last_d  = win_last_q;
        lb_we       = 1'b0;

        // Only a window-completing pixel has to wait for the output slot.
        // Every other pixel flows regardless of backpressure.
        in_ready = !(state_q == PAIR_ODD && col_q[0] && win_valid_q && !win_ready);

        if (win_valid_q && win_ready) begin
            win_valid_d = 1'b0;
            win_last_d  = 1'b0;
        end

        if (in_valid && in_ready) begin
            col_d = col_wrap ? '0 : col_q + CW'(1);
            if (col_wrap)
                row_d = row_wrap ? '0 : row_q + RW'(1);

            case (state_q)
                FILL_EVEN: begin
                    lb_we = 1'b1;
                    if (col_wrap) state_d = PAIR_ODD;
                end
                PAIR_ODD: begin
                    if (!col_q[0]) begin
                        left_d = px;
                    end else begin
                        // A new load overrides a same-cycle output accept.
                        win_data_d  = {px, left_q, top_r, top_l};
                        win_valid_d = 1'b1;
                        win_last_d  = row_wrap && col_wrap;
                    end
                    if (col_wrap) state_d = FILL_EVEN;
                end
                default: state_d = FILL_EVEN;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= FILL_EVEN;
            col_q       <= '0;
            row_q       <= '0;
            left_q      <= '0;
            win_data_q  <= '0;
            win_valid_q <= 1'b0;
            win_last_q  <= 1'b0;
        end else begin
            state_q     <= state_d;
            col_q       <= col_d;
            row_q       <= row_d;
            left_q      <= left_d;
            win_data_q  <= win_data_d;
            win_valid_q <= win_valid_d;
            win_last_q  <= win_last_d;
        end
    end

    // The line buffer content is don't-care after reset. Each even row
    // rewrites it before any odd-row read.
    always_ff @(posedge clk) begin
        if (lb_we) linebuf_q[col_q] <= px;
    end

    assign win_valid = win_valid_q;
    assign win_data  = win_data_q;
    assign win_last  = win_last_q;

endmodule

// File: tb/tb_pool_window_feeder.sv
module tb_pool_window_feeder;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic [7:0]  in_data = 8'h00;
    logic        win_valid;
    logic        win_ready = 1'b0;
    logic [31:0] win_data;
    logic        win_last;

    int n_chk = 0;
    int n_fail = 0;

    pool_window_feeder #(.IMG_W(4), .IMG_H(4)) dut (
        .clk(clk), .rst_n(rst_n),
        .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
        .win_valid(win_valid), .win_ready(win_ready),
        .win_data(win_data), .win_last(win_last)
    );

    always #5 clk = ~clk;

    // Monitor: cycle counter plus logs of pixel accepts, window visibility and
    // window accepts. All are sampled on the falling edge.
    int          cyc = 0;
    int          pcyc[$];
    int          wvis[$];
    logic [31:0] wq_d[$];
    logic        wq_l[$];
    logic        pv = 1'b0, pa = 1'b0;

    always @(posedge clk) cyc++;

    always @(negedge clk) begin
        if (!rst_n) begin
            pv = 1'b0;
            pa = 1'b0;
        end else begin
            if (in_valid && in_ready) pcyc.push_back(cyc);
            if (win_valid && !(pv && !pa)) wvis.push_back(cyc);
            if (win_valid && win_ready) begin
                wq_d.push_back(win_data);
                wq_l.push_back(win_last);
            end
            pv = win_valid;
            pa = win_ready;
        end
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h want %h", tag, obs, exp);
        end
    endtask

    task automatic send_px(input logic [7:0] d);
        int n;
        n = 0;
        in_valid = 1'b1;
        in_data  = d;
        forever begin
            @(negedge clk);
            if (in_ready) break;
            n++;
            if (n > 50) begin
                chk("send_timeout", 32'd0, 32'd1);
                break;
            end
        end
        @(posedge clk); #1;
        in_valid = 1'b0;
    endtask

    task automatic send_range(input int lo, input int hi);
        for (int p = lo; p <= hi; p++) send_px(8'(p));
    endtask

    task automatic do_reset();
        in_valid  = 1'b0;
        win_ready = 1'b0;
        rst_n     = 1'b0;
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;
    endtask

    task automatic idle(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    // Compare four accepted windows from queue index db against the basic frame.
    task automatic chk_frame(input string tag, input int db, input logic [31:0] w0);
        logic [31:0] exp_w[4];
        int          got;
        exp_w[0] = w0;
        exp_w[1] = 32'h08070403;
        exp_w[2] = 32'h0E0D0A09;
        exp_w[3] = 32'h100F0C0B;
        got = wq_d.size() - db;
        chk({tag, "_count"}, 32'(got), 32'd4);
        for (int i = 0; i < 4 && i < got; i++) begin
            chk($sformatf("%s_data%0d", tag, i), wq_d[db+i], exp_w[i]);
            chk($sformatf("%s_last%0d", tag, i), 32'(wq_l[db+i]), 32'(i == 3));
        end
    endtask

    initial begin
        int pb, wb, db;
        logic [31:0] nz_exp;

        // Reset state.
        #2;
        chk("rst_in_ready",  32'(in_ready),  32'd1);
        chk("rst_win_valid", 32'(win_valid), 32'd0);
        chk("rst_win_data",  win_data,       32'h0);
        chk("rst_win_last",  32'(win_last),  32'd0);
        do_reset();

        // Basic packing and latency.
        pb = pcyc.size(); wb = wvis.size(); db = wq_d.size();
        win_ready = 1'b1;
        send_range(1, 16);
        idle(4);
        chk_frame("basic", db, 32'h06050201);
        chk("basic_nbubble", 32'(pcyc.size() - pb), 32'd16);
        if (pcyc.size() - pb >= 16 && wvis.size() - wb >= 4) begin
            chk("basic_lat0", 32'(wvis[wb+0]), 32'(pcyc[pb+5] + 1));
            chk("basic_lat1", 32'(wvis[wb+1]), 32'(pcyc[pb+7] + 1));
            chk("basic_lat2", 32'(wvis[wb+2]), 32'(pcyc[pb+13] + 1));
            chk("basic_lat3", 32'(wvis[wb+3]), 32'(pcyc[pb+15] + 1));
            chk("basic_rate", 32'(pcyc[pb+15] - pcyc[pb]), 32'd15);
        end else begin
            chk("basic_lat_logs", 32'd0, 32'd1);
        end

        // Backpressure: window 1 pending blocks pixel 8 only.
        do_reset();
        pb = pcyc.size(); db = wq_d.size();
        win_ready = 1'b0;
        send_range(1, 7);
        if (pcyc.size() - pb >= 7)
            chk("bp_px1_7_flow", 32'(pcyc[pb+6] - pcyc[pb]), 32'd6);
        else
            chk("bp_px1_7_cnt", 32'(pcyc.size() - pb), 32'd7);
        in_valid = 1'b1;
        in_data  = 8'd8;
        repeat (3) begin
            @(negedge clk);
            chk("bp_in_ready_low", 32'(in_ready), 32'd0);
            chk("bp_hold_data", win_data, 32'h06050201);
        end
        @(posedge clk); #1;
        win_ready = 1'b1;
        send_range(8, 16);
        idle(4);
        chk_frame("bp", db, 32'h06050201);

        // Simultaneous accept of window 1 and load of window 2.
        do_reset();
        db = wq_d.size();
        win_ready = 1'b0;
        send_range(1, 7);
        in_valid  = 1'b1;
        in_data   = 8'd8;
        win_ready = 1'b1;
        @(negedge clk);
        chk("sim_in_ready", 32'(in_ready),  32'd1);
        chk("sim_pre_data", win_data,       32'h06050201);
        @(posedge clk); #1;
        in_valid  = 1'b0;
        win_ready = 1'b0;
        @(negedge clk);
        chk("sim_valid_kept", 32'(win_valid), 32'd1);
        chk("sim_post_data",  win_data,       32'h08070403);
        @(posedge clk); #1;
        win_ready = 1'b1;
        send_range(9, 16);
        idle(4);
        chk_frame("sim", db, 32'h06050201);

        // Back-to-back frames.
        do_reset();
        pb = pcyc.size(); db = wq_d.size();
        win_ready = 1'b1;
        send_range(1, 16);
        send_range(1, 16);
        idle(4);
        chk("b2b_count", 32'(wq_d.size() - db), 32'd8);
        if (wq_d.size() - db >= 8) begin
            for (int i = 0; i < 8; i++)
                chk($sformatf("b2b_last%0d", i), 32'(wq_l[db+i]), 32'(i == 3 || i == 7));
            chk("b2b_f2_w0", wq_d[db+4], 32'h06050201);
            chk("b2b_f2_w3", wq_d[db+7], 32'h100F0C0B);
        end
        if (pcyc.size() - pb >= 32)
            chk("b2b_nbubble", 32'(pcyc[pb+31] - pcyc[pb]), 32'd31);
        else
            chk("b2b_px_cnt", 32'(pcyc.size() - pb), 32'd32);

        // Reset mid-frame, then restart.
        do_reset();
        win_ready = 1'b0;
        send_range(1, 7);
        rst_n = 1'b0;
        @(negedge clk);
        chk("mid_rst_in_ready",  32'(in_ready),  32'd1);
        chk("mid_rst_win_valid", 32'(win_valid), 32'd0);
        chk("mid_rst_win_data",  win_data,       32'h0);
        chk("mid_rst_win_last",  32'(win_last),  32'd0);
        @(posedge clk); #1;
        rst_n = 1'b1;
        db = wq_d.size();
        win_ready = 1'b1;
        send_range(1, 16);
        idle(4);
        chk_frame("restart", db, 32'h06050201);

        // Negative-zero pixel in the bottom-left slot of window 0.
`ifdef POOL_FEED_NEGZERO_SQUASH_EN
        nz_exp = 32'h06000201;
`else
        nz_exp = 32'h06800201;
`endif
        do_reset();
        db = wq_d.size();
        win_ready = 1'b1;
        send_range(1, 4);
        send_px(8'h80);
        send_range(6, 16);
        idle(4);
        chk_frame("negzero", db, nz_exp);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

    // Global watchdog.
    initial begin
        #200000;
        $display("FAIL watchdog: got timeout want finish");
        $fatal(1, "watchdog");
    end

endmodule
